// File: rtl/oc8051_fetch_queue_if.sv
// Bundle of code-ROM word port and decoder byte port seen by the fetch queue.
// master: the fetch queue itself; slave: the ROM/decoder side driving it.
interface oc8051_fetch_queue_if;
  logic        rom_req;
  logic [15:0] rom_addr;
  logic        rom_ack;
  logic [31:0] rom_data;
  logic        dec_valid;
  logic [1:0]  dec_avail;
  logic [15:0] dec_pc;
  logic [7:0]  dec_op0;
  logic [7:0]  dec_op1;
  logic [7:0]  dec_op2;
  logic [1:0]  dec_consume;
  logic        jump;
  logic [15:0] jump_pc;

  modport master (
    output rom_req, rom_addr, dec_valid, dec_avail, dec_pc, dec_op0, dec_op1, dec_op2,
    input  rom_ack, rom_data, dec_consume, jump, jump_pc
  );

  modport slave (
    input  rom_req, rom_addr, dec_valid, dec_avail, dec_pc, dec_op0, dec_op1, dec_op2,
    output rom_ack, rom_data, dec_consume, jump, jump_pc
  );
endinterface

// File: rtl/oc8051_fetch_queue.sv
// 8051 instruction prefetch queue: issues 32-bit code-ROM fetches and feeds
// up to three head bytes plus their PC to the decoder.
//
// state   | meaning
// ST_IDLE | no request outstanding
// ST_BUSY | request outstanding, returned word will be queued
// ST_DROP | request outstanding, a jump happened, returned word is thrown away
module oc8051_fetch_queue #(
  parameter int          QDEPTH   = 8,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input logic             clk,
  input logic             rst,
  oc8051_fetch_queue_if.master bus
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DROP} state_t;

  state_t        state;
  state_t        state_next;
  logic [7:0]    mem [QDEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr1;
  logic [PW-1:0] rd_ptr2;
  logic [CW-1:0] count;
  logic [15:0]   fetch_addr;
  logic [15:0]   dec_pc;
  logic [15:0]   rom_addr;
  logic          issue;
  logic          accept;
  logic [1:0]    avail;
  logic [1:0]    cons;

  // A new fetch only starts when 4 free bytes are guaranteed, so the queue never overflows.
  assign issue   = (state == ST_IDLE) && (count <= CW'(QDEPTH - 4)) && !bus.jump;
  assign accept  = (state == ST_BUSY) && bus.rom_ack && !bus.jump;
  assign avail   = (count >= CW'(3)) ? 2'd3 : count[1:0];
  assign cons    = (bus.dec_consume > avail) ? avail : bus.dec_consume;
  assign rd_ptr1 = rd_ptr + PW'(1);
  assign rd_ptr2 = rd_ptr + PW'(2);

  // Fetch handshake state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next fetch state: a jump with the word still in flight marks it for dropping.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (issue) state_next = ST_BUSY;
      ST_BUSY: begin
        if (bus.rom_ack)   state_next = ST_IDLE;
        else if (bus.jump) state_next = ST_DROP;
      end
      ST_DROP: if (bus.rom_ack) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Request address latches on issue and stays put until the ack, even across a jump.
  always_ff @(posedge clk) begin
    if (rst)        rom_addr <= RESET_PC;
    else if (issue) rom_addr <= fetch_addr;
  end

  // Pointers, byte count and PCs; jump overrides both fill and consume.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      dec_pc     <= RESET_PC;
      fetch_addr <= RESET_PC;
    end else if (bus.jump) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      dec_pc     <= bus.jump_pc;
      fetch_addr <= bus.jump_pc;
    end else begin
      rd_ptr <= rd_ptr + PW'(cons);
      dec_pc <= dec_pc + 16'(cons);
      if (accept) begin
        wr_ptr     <= wr_ptr + PW'(4);
        count      <= count + CW'(4) - CW'(cons);
        fetch_addr <= fetch_addr + 16'd4;
      end else begin
        count <= count - CW'(cons);
      end
    end
  end

  // Byte storage; contents are only meaningful below count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      for (int j = 0; j < 4; j++) mem[wr_ptr + PW'(j)] <= bus.rom_data[8*j +: 8];
    end
  end

  assign bus.rom_req   = (state != ST_IDLE);
  assign bus.rom_addr  = rom_addr;
  assign bus.dec_valid = (count != '0);
  assign bus.dec_avail = avail;
  assign bus.dec_pc    = dec_pc;
  assign bus.dec_op0   = (avail >= 2'd1) ? mem[rd_ptr]  : 8'h00;
  assign bus.dec_op1   = (avail >= 2'd2) ? mem[rd_ptr1] : 8'h00;
  assign bus.dec_op2   = (avail == 2'd3) ? mem[rd_ptr2] : 8'h00;
endmodule

// File: tb/tb_oc8051_fetch_queue.sv
// Bench for the fetch queue: a ROM model answers requests with address-valued bytes,
// stimulus pushes expected fetch addresses and decoder snapshots, monitors compare.
module tb_oc8051_fetch_queue;
  logic clk = 1'b0;
  logic rst;

  oc8051_fetch_queue_if bus();

  oc8051_fetch_queue #(.QDEPTH(8), .RESET_PC(16'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] pc;
    logic [1:0]  avail;
    logic [7:0]  op0;
    logic [7:0]  op1;
    logic [7:0]  op2;
  } dec_t;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_addr [$];
  dec_t        exp_dec [$];
  logic        probe = 1'b0;
  int          lat = 1;
  int          stray_cnt = 0;
  int          stray_done = 0;
  int          rom_wait = 0;
  logic        req_prev = 1'b0;
  logic [15:0] addr_e;
  dec_t        dec_e;
  dec_t        dec_a;

  function automatic logic [31:0] rom_word(input logic [15:0] a);
    logic [31:0] w;
    w = '0;
    for (int j = 0; j < 4; j++) w[8*j +: 8] = 8'(a + 16'(j));
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_dec(input logic [15:0] pc, input logic [1:0] av,
                            input logic [7:0] o0, input logic [7:0] o1, input logic [7:0] o2);
    exp_dec.push_back('{pc: pc, avail: av, op0: o0, op1: o1, op2: o2});
    probe = 1'b1;
    @(negedge clk);
    probe = 1'b0;
  endtask

  task automatic wait_req(input string name, input int budget);
    int n;
    n = 0;
    while (!bus.rom_req && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(bus.rom_req), 32'd1);
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n;
    n = 0;
    while (!bus.dec_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(bus.dec_valid), 32'd1);
  endtask

  // ROM model: ack after lat cycles of rom_req, plus one-shot stray acks on demand.
  initial begin
    bus.rom_ack  = 1'b0;
    bus.rom_data = '0;
    forever begin
      @(negedge clk);
      #1;
      if (bus.rom_ack) begin
        bus.rom_ack = 1'b0;
        rom_wait    = 0;
      end else if (stray_cnt != stray_done) begin
        stray_done++;
        bus.rom_ack  = 1'b1;
        bus.rom_data = 32'hAAAA_AAAA;
      end else if (bus.rom_req) begin
        rom_wait++;
        if (rom_wait >= lat) begin
          bus.rom_ack  = 1'b1;
          bus.rom_data = rom_word(bus.rom_addr);
        end
      end else begin
        rom_wait = 0;
      end
    end
  end

  // Request monitor: every new request must match the next expected fetch address.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (bus.rom_req && !req_prev) begin
        checks++;
        if (exp_addr.size() == 0) begin
          errors++;
          $display("FAIL rom_addr unexpected request actual=%h required=none", bus.rom_addr);
        end else begin
          addr_e = exp_addr.pop_front();
          if (bus.rom_addr !== addr_e) begin
            errors++;
            $display("FAIL rom_addr actual=%h required=%h", bus.rom_addr, addr_e);
          end
        end
      end
      req_prev = bus.rom_req;
    end
  end

  // Decoder monitor: compares the presented head bytes whenever a snapshot is requested.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (probe) begin
        checks++;
        dec_a = '{pc: bus.dec_pc, avail: bus.dec_avail, op0: bus.dec_op0,
                  op1: bus.dec_op1, op2: bus.dec_op2};
        if (exp_dec.size() == 0) begin
          errors++;
          $display("FAIL dec no expectation actual=%h", dec_a);
        end else begin
          dec_e = exp_dec.pop_front();
          if (dec_a !== dec_e)begin
            errors++;
            $display("FAIL dec pc/avail/ops actual=%h/%0d/%h %h %h required=%h/%0d/%h %h %h",
                     dec_a.pc, dec_a.avail, dec_a.op0, dec_a.op1, dec_a.op2,
                     dec_e.pc, dec_e.avail, dec_e.op0, dec_e.op1, dec_e.op2);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b1;
    bus.dec_consume = 2'd0;
    bus.jump        = 1'b0;
    bus.jump_pc     = 16'h0000;
    exp_addr.push_back(16'h0000);
    exp_addr.push_back(16'h0004);
    exp_addr.push_back(16'h0008);
    step(3);
    chk("rst_req",   32'(bus.rom_req),   32'd0);
    chk("rst_addr",  32'(bus.rom_addr),  32'h0000);
    chk("rst_valid", 32'(bus.dec_valid), 32'd0);
    chk("rst_avail", 32'(bus.dec_avail), 32'd0);
    chk("rst_pc",    32'(bus.dec_pc),    32'h0000);
    chk("rst_ops",   {8'h00, bus.dec_op0, bus.dec_op1, bus.dec_op2}, 32'h0);
    rst = 1'b0;

    // first fill, then consume 1,2,3
    wait_valid("t1_fill", 10);
    expect_dec(16'h0000, 2'd3, 8'h00, 8'h01, 8'h02);
    bus.dec_consume = 2'd1; step(1); bus.dec_consume = 2'd0; step(6);
    expect_dec(16'h0001, 2'd3, 8'h01, 8'h02, 8'h03);
    bus.dec_consume = 2'd2; step(1); bus.dec_consume = 2'd0; step(6);
    expect_dec(16'h0003, 2'd3, 8'h03, 8'h04, 8'h05);
    bus.dec_consume = 2'd3; step(1); bus.dec_consume = 2'd0; step(6);
    expect_dec(16'h0006, 2'd3, 8'h06, 8'h07, 8'h08);

    // fill to full, then the issue threshold
    exp_addr.push_back(16'h000C);
    bus.dec_consume = 2'd2; step(1); bus.dec_consume = 2'd0; step(6);
    expect_dec(16'h0008, 2'd3, 8'h08, 8'h09, 8'h0A);
    for (int i = 0; i < 4; i++) begin chk("full_idle", 32'(bus.rom_req), 32'd0); step(1); end
    bus.dec_consume = 2'd3; step(1); bus.dec_consume = 2'd0;
    for (int i = 0; i < 4; i++) begin chk("cnt5_idle", 32'(bus.rom_req), 32'd0); step(1); end
    expect_dec(16'h000B, 2'd3, 8'h0B, 8'h0C, 8'h0D);
    exp_addr.push_back(16'h0010);
    bus.dec_consume = 2'd1; step(1); bus.dec_consume = 2'd0;
    wait_req("cnt4_req", 3);
    step(6);
    expect_dec(16'h000C, 2'd3, 8'h0C, 8'h0D, 8'h0E);

    // jump while a slow fetch is in flight
    lat = 3;
    exp_addr.push_back(16'h0014);
    bus.dec_consume = 2'd3; step(2); bus.dec_consume = 2'd0;
    wait_req("t4_req", 6);
    exp_addr.push_back(16'h1235);
    exp_addr.push_back(16'h1239);
    bus.jump = 1'b1; bus.jump_pc = 16'h1235; step(1); bus.jump = 1'b0;
    bus.dec_consume = 2'd3;
    chk("t4_hold_req",  32'(bus.rom_req),  32'd1);
    chk("t4_hold_addr", 32'(bus.rom_addr), 32'h0014);
    expect_dec(16'h1235, 2'd0, 8'h00, 8'h00, 8'h00);
    bus.dec_consume = 2'd0;
    chk("t4_hold_addr2", 32'(bus.rom_addr), 32'h0014);
    wait_valid("t4_fill", 20);
    expect_dec(16'h1235, 2'd3, 8'h35, 8'h36, 8'h37);
    step(12);

    // address wrap across 0xFFFF
    lat = 1;
    exp_addr.push_back(16'hFFFE);
    exp_addr.push_back(16'h0002);
    bus.jump = 1'b1; bus.jump_pc = 16'hFFFE; step(1); bus.jump = 1'b0;
    step(8);
    expect_dec(16'hFFFE, 2'd3, 8'hFE, 8'hFF, 8'h00);
    bus.dec_consume = 2'd1; step(1); bus.dec_consume = 2'd0;
    expect_dec(16'hFFFF, 2'd3, 8'hFF, 8'h00, 8'h01);
    bus.dec_consume = 2'd1; step(1); bus.dec_consume = 2'd0;
    expect_dec(16'h0000, 2'd3, 8'h00, 8'h01, 8'h02);

    // jump in the same cycle as the ack: word dropped, no discard pending
    exp_addr.push_back(16'h0006);
    exp_addr.push_back(16'h0100);
    exp_addr.push_back(16'h0104);
    bus.dec_consume = 2'd2; step(1); bus.dec_consume = 2'd0;
    wait_req("t5b_req", 4);
    bus.jump = 1'b1; bus.jump_pc = 16'h0100; step(1); bus.jump = 1'b0;
    step(10);
    expect_dec(16'h0100, 2'd3, 8'h00, 8'h01, 8'h02);

    // reset with a request outstanding, stray ack right after release
    lat = 20;
    exp_addr.push_back(16'h0108);
    bus.dec_consume = 2'd3; step(2); bus.dec_consume = 2'd0;
    wait_req("t6_req", 6);
    rst = 1'b1;
    step(2);
    chk("t6_rst_req",   32'(bus.rom_req),   32'd0);
    chk("t6_rst_addr",  32'(bus.rom_addr),  32'h0000);
    chk("t6_rst_valid", 32'(bus.dec_valid), 32'd0);
    chk("t6_rst_pc",    32'(bus.dec_pc),    32'h0000);
    exp_addr.push_back(16'h0000);
    exp_addr.push_back(16'h0004);
    rst = 1'b0;
    lat = 1;
    stray_cnt++;
    step(1);
    chk("t6_req_after",  32'(bus.rom_req),   32'd1);
    chk("t6_addr_after", 32'(bus.rom_addr),  32'h0000);
    chk("t6_valid",      32'(bus.dec_valid), 32'd0);
    wait_valid("t6_fill", 10);
    expect_dec(16'h0000, 2'd3, 8'h00, 8'h01, 8'h02);
    step(10);

    chk("addr_left", 32'(exp_addr.size()), 32'd0);
    chk("dec_left",  32'(exp_dec.size()),  32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
